// File: rtl/mips_fetch_unit_if.sv
// rtl/mips_fetch_unit_if.sv - fetch unit bundle: memory bus 0, redirect request and decode handshake
interface mips_fetch_unit_if #(
  parameter int N = 32
);
  logic [N-1:0] mem_addr;
  logic         mem_wr_ena;
  logic [N-1:0] mem_din;
  logic [N-1:0] mem_dout;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [N-1:0] inst_out;
  logic [N-1:0] inst_pc;

  modport master (
    output mem_addr, mem_wr_ena, mem_din, inst_valid, inst_out, inst_pc,
    input  mem_dout, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_addr, mem_wr_ena, mem_din, inst_valid, inst_out, inst_pc,
    output mem_dout, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - instruction fetch: PC sequencing, one read per cycle, 4-entry queue to decode
module mips_fetch_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h4000_0000,
  parameter int           Q_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rstb,
  mips_fetch_unit_if.master bus
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic          pending_q, pending_d;
  logic [N-1:0]  pending_pc_q, pending_pc_d;
  logic [N-1:0]  q_inst_q [Q_DEPTH];
  logic [N-1:0]  q_inst_d [Q_DEPTH];
  logic [N-1:0]  q_pc_q   [Q_DEPTH];
  logic [N-1:0]  q_pc_d   [Q_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW:0]   occupancy;
  logic          credit;
  logic          issue;
  logic          push;
  logic          pop;

  // Credit counts the in-flight read too, so a returning word always has a slot.
  // A pop this cycle is deliberately not credited back until next cycle.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    credit    = (occupancy <= (CW + 1)'(Q_DEPTH - 1));
    issue     = ~rstb & ~bus.redirect_valid & credit;
    push      = pending_q & ~bus.redirect_valid;
    pop       = (count_q != '0) & bus.inst_ready;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = 1'b0;
    pending_pc_d = pending_pc_q;
    q_inst_d     = q_inst_q;
    q_pc_d       = q_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (bus.redirect_valid) begin
      // Flush drops the returning word and everything queued; low PC bits kept as given.
      fetch_pc_d = bus.redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pending_d    = 1'b1;
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + N'(4);
      end
      if (push) begin
        q_inst_d[wr_ptr_q] = bus.mem_dout;
        q_pc_d[wr_ptr_q]   = pending_pc_q;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      q_inst_q     <= q_inst_d;
      q_pc_q       <= q_pc_d;
    end
  end

  assign bus.mem_addr   = fetch_pc_q;
  assign bus.mem_wr_ena = 1'b0;
  assign bus.mem_din    = '0;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = q_inst_q[rd_ptr_q];
  assign bus.inst_pc    = q_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - vector table, corner sequences and randomized stream check for mips_fetch_unit
module tb_mips_fetch_unit;
  localparam logic [31:0] RPC_A = 32'h4000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  mips_fetch_unit_if #(.N(32)) ifa ();
  mips_fetch_unit_if #(.N(32)) ifb ();

  mips_fetch_unit #(.N(32), .RESET_PC(RPC_A), .Q_DEPTH(4)) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (ifa)
  );

  mips_fetch_unit #(.N(32), .RESET_PC(RPC_B), .Q_DEPTH(4)) dut_wrap (
    .clk (clk),
    .rstb(rstb),
    .bus (ifb)
  );

  // Instruction memory contents: word i of the instruction space holds 0x1000_0000 + i.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h1000_0000 + ((a - 32'h4000_0000) >> 2);
  endfunction

  always @(posedge clk) begin
    ifa.mem_dout <= imem(ifa.mem_addr);
    ifb.mem_dout <= imem(ifb.mem_addr);
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc = RPC_A;
  int          stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    rstb               = r;
    ifa.inst_ready     = rdy;
    ifa.redirect_valid = rv;
    ifa.redirect_pc    = rpc;
    @(negedge clk);
  endtask

  // Reference: decode must see consecutive PCs starting at RESET_PC or the last redirect target.
  task automatic finish_cycle();
    chk("mem_wr_ena", {31'b0, ifa.mem_wr_ena}, 32'd0);
    chk("mem_din", ifa.mem_din, 32'd0);
    chk("count_bound", {31'b0, ({29'b0, dut.count_q} <= 32'd4)}, 32'd1);
    if (!rstb && ifa.inst_valid && ifa.inst_ready) begin
      chk("stream_pc", ifa.inst_pc, exp_pc);
      chk("stream_inst", ifa.inst_out, imem(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (rstb || ifa.redirect_valid) stall = 0;
    else if (ifa.inst_ready && !ifa.inst_valid) stall++;
    else if (ifa.inst_valid) stall = 0;
    chk("stall_bound", {31'b0, (stall <= 3)}, 32'd1);
    if (rstb) exp_pc = RPC_A;
    else if (ifa.redirect_valid) exp_pc = ifa.redirect_pc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h4000_0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h4000_0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h4000_0004};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0008};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_000C};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0010};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0010};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'h4000_0010};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h4000_0004, 32'h4000_0010};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h4000_0008, 32'h4000_0014};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h4000_000C, 32'h4000_0018};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h4000_0010, 32'h4000_001C};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h4000_0014, 32'h4000_0020};

    ifb.inst_ready     = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = 32'h0;

    apply(1'b1, 1'b1, 1'b0, 32'h0);
    finish_cycle();

    // Startup latency, backpressure stall at 0x10, release; wrap instance runs alongside.
    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].rst, tbl[k].rdy, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_valid", k), {31'b0, ifa.inst_valid}, {31'b0, tbl[k].ev});
      if (tbl[k].ev) chk($sformatf("tbl%0d_pc", k), ifa.inst_pc, tbl[k].epc);
      chk($sformatf("tbl%0d_addr", k), ifa.mem_addr, tbl[k].eaddr);
      if (k == 6) chk("full_count", {29'b0, dut.count_q}, 32'd4);
      if (k >= 3 && k <= 6) begin
        chk($sformatf("wrap%0d_valid", k), {31'b0, ifb.inst_valid}, 32'd1);
        chk($sformatf("wrap%0d_pc", k), ifb.inst_pc, RPC_B + 32'(4 * (k - 3)));
        chk($sformatf("wrap%0d_inst", k), ifb.inst_out, imem(RPC_B + 32'(4 * (k - 3))));
      end
      finish_cycle();
    end

    // Redirect while pending = 1 and count = 3.
    apply(1'b1, 1'b0, 1'b0, 32'h0); finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0); finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0); finish_cycle();
    apply(1'b0, 1'b0, 1'b0, 32'h0); finish_cycle();
    apply(1'b0, 1'b0, 1'b0, 32'h0); finish_cycle();
    apply(1'b0, 1'b0, 1'b1, 32'h4000_0100);
    chk("rdA_count", {29'b0, dut.count_q}, 32'd3);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdA_r1_valid", {31'b0, ifa.inst_valid}, 32'd0);
    chk("rdA_r1_addr", ifa.mem_addr, 32'h4000_0100);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdA_r2_valid", {31'b0, ifa.inst_valid}, 32'd0);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdA_r3_valid", {31'b0, ifa.inst_valid}, 32'd1);
    chk("rdA_r3_pc", ifa.inst_pc, 32'h4000_0100);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0); finish_cycle();
    end

    // Redirect in the same cycle as a completed handshake.
    apply(1'b0, 1'b1, 1'b1, 32'h4000_0200);
    chk("rdB_hs_valid", {31'b0, ifa.inst_valid}, 32'd1);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdB_r1_valid", {31'b0, ifa.inst_valid}, 32'd0);
    chk("rdB_r1_addr", ifa.mem_addr, 32'h4000_0200);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0); finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdB_r3_pc", ifa.inst_pc, 32'h4000_0200);
    finish_cycle();

    // One-cycle reset with a full queue.
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0); finish_cycle();
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_full_count", {29'b0, dut.count_q}, 32'd4);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_r1_valid", {31'b0, ifa.inst_valid}, 32'd0);
    chk("rst_r1_addr", ifa.mem_addr, RPC_A);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_r2_valid", {31'b0, ifa.inst_valid}, 32'd0);
    finish_cycle();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_r3_pc", ifa.inst_pc, RPC_A);
    finish_cycle();

    // Random backpressure and redirects against the stream reference.
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 39) == 0);
      rpc = 32'h4000_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
      apply(1'b0, rdy, rv, rpc);
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage that drives bus 0 of the dual-port memory and hands instructions to decode. Holds the fetch PC, issues one read per cycle into the memory's 1-cycle registered read path, and captures returned words into a 4-entry instruction queue with a valid/ready handshake. Supports single-cycle redirect from decode/execute, squashing every in-flight and queued instruction.

## Interface
- N, 32, bus width (address and instruction)
- RESET_PC, 32'h4000_0000, fetch PC after reset (start of instruction address space)
- Q_DEPTH, 4, instruction queue entries (power of two, ≥ 3)
- clk  in  1  rising-edge clock
- rstb  in  1  reset, synchronous, active-high (1 = reset)
- mem_addr  out  N  memory bus 0 address; always equals fetch_pc
- mem_wr_ena  out  1  memory bus 0 write enable; constant 0
- mem_din  out  N  memory bus 0 write data; constant 0
- mem_dout  in  N  memory bus 0 read data, valid the cycle after the address is presented
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  N  new fetch PC
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts queue head
- inst_out  out  N  queue head instruction word
- inst_pc  out  N  address of inst_out

## Operation
- State: fetch_pc (N), pending (1) + pending_pc (N), queue (Q_DEPTH × 2N) with rd/wr pointers and count (log2(Q_DEPTH)+1 bits).
- Issue condition: issue = ~rstb & ~redirect_valid & (count + pending ≤ Q_DEPTH−1), using current-cycle registered values (no same-cycle pop credit).
- On issue: pending ← 1, pending_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (mod 2^N, wraps FFFF_FFFC → 0000_0000). Otherwise pending ← 0, fetch_pc held.
- Return: when pending = 1 and no redirect, push {pending_pc, mem_dout} at wr pointer.
- Pop: inst_valid & inst_ready advances rd pointer. Push and pop in the same cycle leave count unchanged; pointers wrap modulo Q_DEPTH.
- inst_valid = (count ≠ 0); inst_out/inst_pc read from rd pointer (combinational off queue registers).
- Redirect (highest priority after reset): fetch_pc ← redirect_pc, pending ← 0, queue pointers and count ← 0. The returning word for any pending read is dropped; no issue that cycle. A handshake completing in the redirect cycle counts as accepted by decode. redirect_pc[1:0] passed through unmodified (memory ignores them).
- Overflow is impossible by credit rule; a push when count = Q_DEPTH is a design error (assertion in bench).

## Timing
- Reset values: fetch_pc = RESET_PC, pending = 0, count = 0, inst_valid = 0, mem_wr_ena = 0, mem_din = 0, mem_addr = RESET_PC.
- Reset mid-operation: all state returns to reset values at the next edge; pending data discarded.
- Fetch latency: address issued cycle T → pushed end of T+1 → inst_valid in T+2.
- Throughput: 1 instruction/cycle sustained with inst_ready held high (steady state count = 1, pending = 1).
- First cycle with rstb = 0 issues RESET_PC; inst_valid first rises 2 cycles later.
- Redirect at cycle R: inst_valid = 0 from R+1; redirect_pc issued R+1; inst_valid with inst_pc = redirect_pc at R+3.
- Backpressure: with inst_ready = 0, count saturates at Q_DEPTH; issue stops when count + pending = Q_DEPTH; no instruction lost or duplicated on release.

## Test plan
- Reset then inst_ready = 1, IMEM words 0..7 = 0x1000_0000+i → inst_pc 0x4000_0000, 04, 08… one per cycle from cycle 2, inst_out matching.
- Hold inst_ready = 0 for 10 cycles then release → count peaks at 4, mem_addr stalls at 0x4000_0010, subsequent stream in-order with no gaps/duplicates.
- Redirect to 0x4000_0100 while pending = 1 and count = 3 → inst_valid = 0 next cycle, stale word never appears, inst_pc = 0x4000_0100 exactly 3 cycles after redirect.
- Redirect coinciding with inst_valid & inst_ready → popped word counted once, queue empty next cycle, fetch restarts at redirect_pc.
- RESET_PC = 32'hFFFF_FFF8, ready = 1 → inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rstb for one cycle with queue full → next cycle inst_valid = 0, mem_addr = RESET_PC, stream restarts from RESET_PC with 2-cycle latency.
